// File: rtl/button_event_if.sv
// Event port between the button event arbiter and its consumer: one event
// per valid/ready handshake, plus the sticky overflow flag and its clear.
interface button_event_if #(
    parameter int NUM_BUTTONS = 4
);
    localparam int IDW = $clog2(NUM_BUTTONS);

    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic [1:0]     evt_kind;
    logic           evt_overflow;
    logic           clr_overflow;

    modport master (
        output evt_valid, evt_id, evt_kind, evt_overflow,
        input  evt_ready, clr_overflow
    );

    modport slave (
        input  evt_valid, evt_id, evt_kind, evt_overflow,
        output evt_ready, clr_overflow
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into PRESS/LONG/RELEASE events and serializes
// them round-robin onto a single registered valid/ready event port.
//
// state | meaning
// IDLE  | button released, waiting for a rise
// HELD  | pressed, hold_cnt counting toward LONG
// LONG  | LONG already reported, hold_cnt frozen until release
module button_event_arbiter #(
    parameter int          NUM_BUTTONS       = 4,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd12000000
) (
    input  logic                   hwclk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_db,
    button_event_if.master         evt
);
    localparam int IDW = $clog2(NUM_BUTTONS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    logic [NUM_BUTTONS-1:0] btn_q, btn_prev, rise, fall;
    state_t                 st_q   [NUM_BUTTONS];
    state_t                 st_d   [NUM_BUTTONS];
    logic [31:0]            cnt_q  [NUM_BUTTONS];
    logic [31:0]            cnt_d  [NUM_BUTTONS];
    // Pending and set vectors per channel: bit0 press, bit1 long, bit2 release
    logic [2:0]             pend_q [NUM_BUTTONS];
    logic [2:0]             set_ev [NUM_BUTTONS];
    logic [2:0]             grant  [NUM_BUTTONS];

    logic           valid_q, ovf_q;
    logic [IDW-1:0] id_q, rr_ptr, win_id, rr_next;
    logic [1:0]     kind_q, win_kind;
    logic [2:0]     win_pend, win_onehot;
    logic           have_win, load, drop;
    int             arb_idx;

    assign rise = btn_q & ~btn_prev;
    assign fall = ~btn_q & btn_prev;

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            set_ev[i] = 3'b000;
            case (st_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        set_ev[i] = 3'b001;
                        cnt_d[i]  = 32'd0;
                        st_d[i]   = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        set_ev[i] = 3'b100;
                        st_d[i]   = ST_IDLE;
                    end else if (cnt_q[i] == LONG_PRESS_CYCLES - 32'd1) begin
                        set_ev[i] = 3'b010;
                        st_d[i]   = ST_LONG;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                ST_LONG: begin
                    if (fall[i]) begin
                        set_ev[i] = 3'b100;
                        st_d[i]   = ST_IDLE;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    // Round-robin search from rr_ptr; within a channel PRESS > LONG > RELEASE
    always_comb begin
        have_win = 1'b0;
        win_id   = '0;
        arb_idx  = 0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NUM_BUTTONS;
            if (!have_win && (|pend_q[arb_idx])) begin
                have_win = 1'b1;
                win_id   = IDW'(arb_idx);
            end
        end
        win_pend = pend_q[win_id];
        if (win_pend[0]) begin
            win_kind   = 2'b00;
            win_onehot = 3'b001;
        end else if (win_pend[1]) begin
            win_kind   = 2'b01;
            win_onehot = 3'b010;
        end else begin
            win_kind   = 2'b10;
            win_onehot = 3'b100;
        end
        load    = have_win && (!valid_q || evt.evt_ready);
        rr_next = (win_id == IDW'(NUM_BUTTONS - 1)) ? '0 : win_id + 1'b1;
    end

    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            grant[i] = (load && (win_id == IDW'(i))) ? win_onehot : 3'b000;
            if (|(set_ev[i] & pend_q[i] & ~grant[i]))
                drop = 1'b1;
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            btn_q    <= '0;
            btn_prev <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            kind_q   <= 2'b00;
            ovf_q    <= 1'b0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                st_q[i]   <= ST_IDLE;
                cnt_q[i]  <= 32'd0;
                pend_q[i] <= 3'b000;
            end
        end else begin
            btn_q    <= btn_db;
            btn_prev <= btn_q;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= (pend_q[i] & ~grant[i]) | set_ev[i];
            end
            if (drop)
                ovf_q <= 1'b1;
            else if (evt.clr_overflow)
                ovf_q <= 1'b0;
            if (load) begin
                valid_q <= 1'b1;
                id_q    <= win_id;
                kind_q  <= win_kind;
                rr_ptr  <= rr_next;
            end else if (valid_q && evt.evt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid    = valid_q;
    assign evt.evt_id       = id_q;
    assign evt.evt_kind     = kind_q;
    assign evt.evt_overflow = ovf_q;
endmodule
